// File: rtl/conv3_pkg.sv
// Shared constants, FSM state type and the rate-1/2 K=3 (5,7 octal) encoder
// function for the conv3 frame sequencer.
package conv3_pkg;

  localparam int K        = 3;
  localparam int TAIL_LEN = K - 1;

  localparam logic [2:0] G1 = 3'b101;
  localparam logic [2:0] G2 = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    TAIL,
    FLUSH
  } conv3_state_t;

  // Tap vector is {b, s0, s1}: newest bit in the MSB, so G1=101 selects b and s1.
  function automatic logic [1:0] conv3_encode(input logic b, input logic [1:0] s);
    logic [2:0] taps;
    taps = {b, s[0], s[1]};
    return {^(taps & G1), ^(taps & G2)};
  endfunction

endpackage

// File: rtl/conv3_enc_core.sv
// Encoder shift state {s1,s0} with clear/load control; the symbol for the
// presented bit is combinational from the current state.
module conv3_enc_core
  import conv3_pkg::*;
(
  input  logic       clock,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic       bit_i,
  output logic [1:0] sym_o
);

  logic [1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = 2'b00;
    end else if (load_i) begin
      state_d = {state_q[0], bit_i};
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 2'b00;
    end else begin
      state_q <= state_d;
    end
  end

  assign sym_o = conv3_encode(bit_i, state_q);

endmodule

// File: rtl/conv3_frame_ctrl.sv
// Frame sequencer: payload bits -> K=3 encoder -> zero tail -> registered symbol stream.
// Optional CONV3_NOISE_EN adds noise_en and flips sym_out2 on every third symbol.
module conv3_frame_ctrl
  import conv3_pkg::*;
#(
  parameter int FRAME_LEN = 16
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       sym_out1,
  output logic       sym_out2,
  output logic       sym_last,
  output logic       frame_done,
`ifdef CONV3_NOISE_EN
  input  logic       noise_en,
`endif
  output logic [7:0] frame_cnt
);

  localparam int BW = $clog2(FRAME_LEN + 1);
  localparam int SW = $clog2(FRAME_LEN + TAIL_LEN + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_LEN - 1);
  localparam logic [SW-1:0] LAST_SYM = SW'(FRAME_LEN + TAIL_LEN - 1);

  conv3_state_t state_q, state_d;
  logic [BW-1:0] bitCnt_q, bitCnt_d;
  logic [SW-1:0] symIdx_q, symIdx_d;
  logic          symValid_q, symValid_d;
  logic          symOut1_q, symOut1_d;
  logic          symOut2_q, symOut2_d;
  logic          symLast_q, symLast_d;
  logic          frameDone_q, frameDone_d;
  logic [7:0]    frameCnt_q, frameCnt_d;

  logic       adv;
  logic       consume;
  logic       codedBit;
  logic       clearEnc;
  logic       lastHs;
  logic       noiseFlip;
  logic [1:0] encSym;

  conv3_enc_core u_enc (
    .clock   (clock),
    .rst_n   (rst_n),
    .clear_i (clearEnc),
    .load_i  (consume),
    .bit_i   (codedBit),
    .sym_o   (encSym)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = PAYLOAD;
      PAYLOAD: if (consume && (bitCnt_q == LAST_BIT)) state_d = TAIL;
      TAIL:    if (consume && (symIdx_q == LAST_SYM)) state_d = FLUSH;
      FLUSH:   if (lastHs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A bit (payload or tail zero) is consumed whenever the output register can take a symbol.
  always_comb begin
    adv      = !symValid_q || sym_ready;
    lastHs   = symValid_q && sym_ready && symLast_q;
    busy     = (state_q != IDLE);
    in_ready = 1'b0;
    consume  = 1'b0;
    codedBit = 1'b0;
    clearEnc = 1'b0;
    unique case (state_q)
      IDLE:    clearEnc = start;
      PAYLOAD: begin
        in_ready = adv;
        consume  = adv && in_valid;
        codedBit = in_bit;
      end
      TAIL:    consume = adv;
      FLUSH:   ;
      default: ;
    endcase
  end

`ifdef CONV3_NOISE_EN
  assign noiseFlip = noise_en && ((symIdx_q % SW'(3)) == SW'(2));
`else
  assign noiseFlip = 1'b0;
`endif

  always_comb begin
    bitCnt_d    = bitCnt_q;
    symIdx_d    = symIdx_q;
    symValid_d  = symValid_q;
    symOut1_d   = symOut1_q;
    symOut2_d   = symOut2_q;
    symLast_d   = symLast_q;
    frameDone_d = lastHs;
    frameCnt_d  = frameCnt_q + 8'(lastHs);
    if (clearEnc) begin
      bitCnt_d = '0;
      symIdx_d = '0;
    end
    if (consume) begin
      symIdx_d   = symIdx_q + SW'(1);
      symValid_d = 1'b1;
      symOut1_d  = encSym[1];
      symOut2_d  = encSym[0] ^ noiseFlip;
      symLast_d  = (state_q == TAIL) && (symIdx_q == LAST_SYM);
      if (state_q == PAYLOAD) begin
        bitCnt_d = bitCnt_q + BW'(1);
      end
    end else if (sym_ready) begin
      symValid_d = 1'b0;
      symLast_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bitCnt_q    <= '0;
      symIdx_q    <= '0;
      symValid_q  <= 1'b0;
      symOut1_q   <= 1'b0;
      symOut2_q   <= 1'b0;
      symLast_q   <= 1'b0;
      frameDone_q <= 1'b0;
      frameCnt_q  <= 8'd0;
    end else begin
      bitCnt_q    <= bitCnt_d;
      symIdx_q    <= symIdx_d;
      symValid_q  <= symValid_d;
      symOut1_q   <= symOut1_d;
      symOut2_q   <= symOut2_d;
      symLast_q   <= symLast_d;
      frameDone_q <= frameDone_d;
      frameCnt_q  <= frameCnt_d;
    end
  end

  assign sym_valid  = symValid_q;
  assign sym_out1   = symOut1_q;
  assign sym_out2   = symOut2_q;
  assign sym_last   = symLast_q;
  assign frame_done = frameDone_q;
  assign frame_cnt  = frameCnt_q;

endmodule

// File: tb/tb_conv3_frame_ctrl.sv
// Self-checking bench for conv3_frame_ctrl (FRAME_LEN=4): convolution-level model,
// per-cycle compare process, directed literal frames and randomized traffic.
module tb_conv3_frame_ctrl;

  localparam int FL = 4;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       sym_valid;
  logic       sym_ready;
  logic       sym_out1;
  logic       sym_out2;
  logic       sym_last;
  logic       frame_done;
  logic [7:0] frame_cnt;
`ifdef CONV3_NOISE_EN
  logic       noise_en;
`endif

  always #5 clock = ~clock;

  conv3_frame_ctrl #(.FRAME_LEN(FL)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bit     (in_bit),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_out1   (sym_out1),
    .sym_out2   (sym_out2),
    .sym_last   (sym_last),
    .frame_done (frame_done),
`ifdef CONV3_NOISE_EN
    .noise_en   (noise_en),
`endif
    .frame_cnt  (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model state: bits of the current frame, symbol index, busy/done/count expectations
  logic       bitsQ[$];
  logic [2:0] capQ[$];
  int         symK = 0;
  bit         modelBusy = 1'b0;
  bit         nextBusy;
  bit         expDone = 1'b0;
  int         modelCnt = 0;
  bit         prevStall = 1'b0;
  logic [2:0] held;
  logic [1:0] expS;

`ifdef CONV3_NOISE_EN
  logic [1:0] litSyms [6] = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
`else
  logic [1:0] litSyms [6] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
`endif

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic uAt(int j);
    if (j < 0 || j >= bitsQ.size()) return 1'b0;
    return bitsQ[j];
  endfunction

  // Symbol k of the frame: code of payload bits followed by zero tail.
  function automatic logic [1:0] expSym(int k);
    logic o1, o2;
    o1 = uAt(k) ^ uAt(k - 2);
    o2 = uAt(k) ^ uAt(k - 1) ^ uAt(k - 2);
`ifdef CONV3_NOISE_EN
    if (k % 3 == 2) o2 = ~o2;
`endif
    return {o1, o2};
  endfunction

  always @(negedge clock) begin
    if (!rst_n) begin
      checkOutput("reset_outputs",
                  32'({busy, in_ready, sym_valid, sym_out1, sym_out2, sym_last, frame_done, frame_cnt}),
                  32'd0);
      bitsQ.delete();
      symK      = 0;
      modelBusy = 1'b0;
      expDone   = 1'b0;
      modelCnt  = 0;
      prevStall = 1'b0;
    end else begin
      checkOutput("busy", 32'(busy), 32'(modelBusy));
      checkOutput("frame_done", 32'(frame_done), 32'(expDone));
      checkOutput("frame_cnt", 32'(frame_cnt), 32'(modelCnt));
      if (prevStall)
        checkOutput("stall_hold", 32'({sym_valid, sym_out1, sym_out2, sym_last}), 32'({1'b1, held}));
      if (sym_valid && !sym_ready)
        checkOutput("in_ready_stall", 32'(in_ready), 32'd0);
      if (!modelBusy)
        checkOutput("in_ready_idle", 32'(in_ready), 32'd0);
      expDone  = 1'b0;
      nextBusy = modelBusy;
      if (!modelBusy && start) nextBusy = 1'b1;
      if (sym_valid && sym_ready) begin
        expS = expSym(symK);
        if (symK < FL)
          checkOutput("sym_before_bit", 32'(symK < bitsQ.size()), 32'd1);
        checkOutput("symbol", 32'({sym_out1, sym_out2, sym_last}), 32'({expS, symK == FL + 1}));
        capQ.push_back({sym_out1, sym_out2, sym_last});
        if (symK == FL + 1) begin
          symK = 0;
          bitsQ.delete();
          expDone  = 1'b1;
          modelCnt = (modelCnt + 1) % 256;
          nextBusy = 1'b0;
        end else begin
          symK++;
        end
      end
      if (in_valid && in_ready) begin
        checkOutput("bit_overrun", 32'(bitsQ.size() < FL), 32'd1);
        bitsQ.push_back(in_bit);
      end
      prevStall = sym_valid && !sym_ready;
      held      = {sym_out1, sym_out2, sym_last};
      modelBusy = nextBusy;
    end
  end

  // One cycle: drive inputs, report acceptance seen at the negedge, return at posedge+1.
  task automatic applyStimulus(input logic s, input logic v, input logic b, input logic r,
                               output logic acc);
    start     = s;
    in_valid  = v;
    in_bit    = b;
    sym_ready = r;
    @(negedge clock);
    acc = in_valid && in_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic waitIdle();
    logic acc;
    int cyc = 0;
    while (busy && cyc < 50) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, acc);
      cyc++;
    end
    checkOutput("idle_timeout", 32'(busy), 32'd0);
  endtask

  // readyMode 0: sym_ready held high; 1: toggles 1,0,...  startNoise: random start pulses.
  task automatic sendFrame(input logic [FL-1:0] bits, input bit readyMode, input bit startNoise);
    logic acc;
    int i = 0;
    int cyc = 0;
    capQ.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, acc);
    while (capQ.size() < FL + 2 && cyc < 100) begin
      applyStimulus(startNoise ? 1'($urandom_range(0, 1)) : 1'b0,
                    i < FL, (i < FL) ? bits[i] : 1'b0,
                    readyMode ? (cyc % 2 == 0) : 1'b1, acc);
      if (acc) i++;
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    checkOutput("frame_symbols", 32'(capQ.size()), 32'(FL + 2));
  endtask

  task automatic checkLiteral(input string name);
    for (int j = 0; j < 6; j++) begin
      if (j < capQ.size()) begin
        checkOutput(name, 32'(capQ[j][2:1]), 32'(litSyms[j]));
        checkOutput("lit_last", 32'(capQ[j][0]), 32'(j == 5));
      end
    end
  endtask

  logic acc;
  int   frames;
  int   gapRun;
  int   maxGap;
  int   cyc;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    sym_ready = 1'b1;
`ifdef CONV3_NOISE_EN
    noise_en  = 1'b1;
`endif
    repeat (3) @(posedge clock);
    #1;
    rst_n = 1'b1;

    // Mid-frame reset after two symbols, then a clean frame
    capQ.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, acc);
    cyc = 0;
    frames = 0;
    while (capQ.size() < 2 && cyc < 20) begin
      applyStimulus(1'b0, 1'b1, 1'(frames % 2), 1'b1, acc);
      if (acc) frames++;
      cyc++;
    end
    checkOutput("midframe_syms", 32'(capQ.size()), 32'd2);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, acc);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, acc);
    checkOutput("cnt_after_rst", 32'(frame_cnt), 32'd0);

    sendFrame(4'b1101, 1'b0, 1'b0);
    checkLiteral("lit_after_rst");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, acc);
    checkOutput("cnt_frame1", 32'(frame_cnt), 32'd1);

    sendFrame(4'b1101, 1'b1, 1'b0);
    checkLiteral("lit_stalled");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, acc);
    checkOutput("cnt_frame2", 32'(frame_cnt), 32'd2);

    sendFrame(4'b1101, 1'b0, 1'b1);
    checkLiteral("lit_start_ignored");
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, acc);
    checkOutput("no_extra_syms", 32'(capQ.size()), 32'd6);
    checkOutput("cnt_frame3", 32'(frame_cnt), 32'd3);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
    end
    waitIdle();

    // 256 back-to-back frames from reset: counter wraps, at most one idle cycle between frames
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, acc);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, acc);
    frames = 0;
    gapRun = 0;
    maxGap = 0;
    cyc    = 0;
    while (frames < 256 && cyc < 4000) begin
      applyStimulus(frame_done, 1'b1, 1'($urandom_range(0, 1)), 1'b1, acc);
      if (frame_done) frames++;
      if (!busy) gapRun++;
      else gapRun = 0;
      if (gapRun > maxGap) maxGap = gapRun;
      cyc++;
    end
    start = 1'b0;
    checkOutput("b2b_frames", 32'(frames), 32'd256);
    checkOutput("cnt_wrap", 32'(frame_cnt), 32'd0);
    checkOutput("max_idle_gap", 32'(maxGap), 32'd1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/conv3_frame_ctrl.md
# conv3_frame_ctrl

Frame sequencer for the rate-1/2, K=3 convolutional encoder (generators 5/7 octal). Accepts a fixed-length frame of payload bits over a valid/ready stream, runs them through the encoder, and appends K-1 zero tail bits so every frame terminates in the zero state. Coded symbol pairs leave on a registered valid/ready stream toward the channel/noise path. It sits between the bit source and the channel model, and it owns all sequencing of the encoder.

## Interface
- `FRAME_LEN`, default 16: payload bits per frame; legal range 1..255.
- `clock` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: frame start request; sampled only in IDLE.
- `busy` out 1: high from the accepted start until the last symbol handshake.
- `in_valid` in 1: payload bit valid.
- `in_ready` out 1: payload bit accepted when `in_valid & in_ready`.
- `in_bit` in 1: payload bit.
- `sym_valid` out 1: coded symbol valid.
- `sym_ready` in 1: downstream accepts the symbol.
- `sym_out1` out 1: coded bit from G1 = b ^ s1.
- `sym_out2` out 1: coded bit from G2 = b ^ s0 ^ s1.
- `sym_last` out 1: qualifies the final tail symbol of the frame.
- `frame_done` out 1: one-cycle pulse on the last-symbol handshake.
- `frame_cnt` out 8: completed-frame count; wraps 255 to 0.
- `noise_en` in 1: present only with `CONV3_NOISE_EN`.

## Operation
- FSM states: IDLE, PAYLOAD, TAIL, FLUSH.
  - IDLE to PAYLOAD on `start`. This clears encoder state {s1,s0}=00 and the bit counter.
  - PAYLOAD to TAIL after FRAME_LEN accepted bits.
  - TAIL to FLUSH after 2 internally generated zero bits are consumed.
  - FLUSH to IDLE on the handshake of the symbol flagged `sym_last`.
- Advance condition: adv = `!sym_valid | sym_ready`.
  - `in_ready` = PAYLOAD & adv.
  - In TAIL, one zero bit is consumed per cycle while adv holds.
- On each consumed bit b:
  - The output register loads (b^s1, b^s0^s1).
  - `sym_valid` is set.
  - Then s1 is loaded with s0, and s0 with b.
- `sym_valid` clears on handshake when no new bit is consumed that cycle.
- While `sym_valid & !sym_ready`, `sym_out1`, `sym_out2` and `sym_last` hold stable.
- `sym_last` is set together with the symbol of the second tail bit.
- `start` is ignored outside IDLE. `start` is allowed in the same cycle that `frame_done` pulses; it is taken the next cycle (IDLE).
- Bit counter width is $clog2(FRAME_LEN+1). The symbol index counter is sized to count FRAME_LEN+2 symbols.

## Timing
- Reset values: `busy`=0, `in_ready`=0, `sym_valid`=0, `sym_out1`=0, `sym_out2`=0, `sym_last`=0, `frame_done`=0, `frame_cnt`=0.
- Reset also forces FSM to IDLE and encoder state to 00.
- Reset mid-frame discards the frame without a `frame_done` pulse.
- Latency: bit accepted at edge t; its symbol is valid after edge t (visible cycle t+1).
- Throughput: one symbol per cycle with `sym_ready` held high.
- Frame length on the output is exactly FRAME_LEN+2 symbols.
- `busy` rises the cycle after `start` is sampled and falls the cycle after the last handshake.
- `frame_cnt` increments on the same edge `frame_done` is registered.

## Configuration
- `CONV3_NOISE_EN` defined:
  - Adds port `noise_en` and a deterministic error injector on the output register.
  - When `noise_en`=1 at bit consumption, `sym_out2` is inverted for symbols whose in-frame index mod 3 == 2 (indices 2, 5, 8, …).
  - This guarantees at most one channel error per 3 symbols.
- Undefined: no port, no injector logic, and outputs are the pure code.

## Structure
- Package `conv3_pkg` holds:
  - K=3, TAIL_LEN=2.
  - G1=3'b101, G2=3'b111.
  - FSM state enum `conv3_state_t`.
  - Function `conv3_encode(b, s)` returning the 2-bit symbol.
- Sub-module `conv3_enc_core` holds encoder state and symbol computation. It has a load/clear interface and is instantiated once.

## Test plan
- FRAME_LEN=4, bits 1,0,1,1, `sym_ready`=1 → symbols (out1,out2) = 11,01,00,10,10,11. `sym_last` is on the 6th symbol, `frame_done` pulses once, `frame_cnt`=1.
- Same frame with `sym_ready` toggling 1,0 → identical symbol sequence. `in_ready`=0 during stalls. Outputs are stable while stalled.
- `start` pulses during PAYLOAD and FLUSH → ignored. Exactly 6 symbols result, and `busy` stays high throughout.
- Reset asserted after 2 symbols, then a new frame of 1,0,1,1 → outputs restart with 11, and `frame_cnt` is unchanged at 0.
- 256 back-to-back frames with `start` on each `frame_done` → `frame_cnt` wraps to 0, with no idle gap beyond 1 cycle.
- With `CONV3_NOISE_EN` and `noise_en`=1, frame 1,0,1,1 → 11,01,01,10,10,10.
